pll_lock_sequencer: RTL



---
 rtl/pll_lock_sequencer.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/pll_lock_sequencer.sv
// Power-up and recovery sequencer for the iCE40 SB_PLL40_CORE: holds the PLL in reset,
// qualifies LOCK, releases downstream reset, retries on lock failure and falls back to bypass.
module pll_lock_sequencer #(
  parameter int RESET_CYCLES = 16,
  parameter int LOCK_TIMEOUT = 4096,
  parameter int LOCK_STABLE  = 64,
  parameter int MAX_RETRIES  = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pll_lock,
  input  logic       relock_req,
  output logic       pll_resetb,
  output logic       pll_bypass,
  output logic       sys_rst_n,
  output logic       locked,
  output logic       fail,
  output logic [2:0] retry_count
);

  localparam int MAX_RT  = (RESET_CYCLES > LOCK_TIMEOUT) ? RESET_CYCLES : LOCK_TIMEOUT;
  localparam int MAX_ALL = (MAX_RT > LOCK_STABLE) ? MAX_RT : LOCK_STABLE;
  localparam int CNT_W   = $clog2(MAX_ALL);

  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] WAIT_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE - 1);
  localparam logic [2:0]       RETRY_LIMIT = 3'(MAX_RETRIES);

  typedef enum logic [2:0] {
    HOLD,
    WAIT_LOCK,
    STABLE,
    RUN,
    BYPASS
  } state_t;

  typedef struct packed {
    logic pll_resetb;
    logic pll_bypass;
    logic sys_rst_n;
    logic locked;
    logic fail;
  } outs_t;

  state_t           state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [2:0]       retry_d;
  logic [1:0]       sync;
  logic             lock_s;
  outs_t            outs_d;

  assign lock_s = sync[1];

  // State register; outputs are registered from the next-state decode so they move with the state.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments make every flop sample pre-edge values, so order here is irrelevant.
    if (!rst_n) begin
      sync        <= '0;
      state       <= HOLD;
      cnt         <= '0;
      retry_count <= '0;
      pll_resetb  <= 1'b0;
      pll_bypass  <= 1'b0;
      sys_rst_n   <= 1'b0;
      locked      <= 1'b0;
      fail        <= 1'b0;
    end else begin
      sync        <= {sync[0], pll_lock};
      state       <= state_d;
      cnt         <= cnt_d;
      retry_count <= retry_d;
      pll_resetb  <= outs_d.pll_resetb;
      pll_bypass  <= outs_d.pll_bypass;
      sys_rst_n   <= outs_d.sys_rst_n;
      locked      <= outs_d.locked;
      fail        <= outs_d.fail;
    end
  end

  // Next state: relock beats every other event; a seen lock beats a coincident timeout.
  always_comb begin
    // NOTE: defaults first so every path assigns each variable and no latch is inferred.
    state_d = state;
    retry_d = retry_count;
    if (relock_req && state != HOLD) begin
      state_d = HOLD;
      retry_d = '0;
    end else begin
      case (state)
        HOLD: begin
          if (cnt == HOLD_LAST) state_d = WAIT_LOCK;
        end
        WAIT_LOCK: begin
          if (lock_s) begin
            state_d = STABLE;
          end else if (cnt == WAIT_LAST) begin
            if (retry_count == RETRY_LIMIT) begin
              state_d = BYPASS;
            end else begin
              state_d = HOLD;
              retry_d = retry_count + 3'd1;
            end
          end
        end
        STABLE: begin
          if (!lock_s) begin
            state_d = WAIT_LOCK;
          end else if (cnt == STABLE_LAST) begin
            state_d = RUN;
            retry_d = '0;
          end
        end
        RUN: begin
          if (!lock_s) state_d = HOLD;
        end
        BYPASS: begin
          state_d = BYPASS;
        end
        default: begin
          state_d = HOLD;
        end
      endcase
    end

    // RUN and BYPASS never time anything, so their counter parks at zero.
    if (state_d != state || state == RUN || state == BYPASS) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt + 1'b1;
    end
  end

  // Output decode of the next state.
  always_comb begin
    outs_d = '0;
    case (state_d)
      HOLD:      outs_d = '{pll_resetb: 1'b0, pll_bypass: 1'b0, sys_rst_n: 1'b0, locked: 1'b0, fail: 1'b0};
      WAIT_LOCK: outs_d = '{pll_resetb: 1'b1, pll_bypass: 1'b0, sys_rst_n: 1'b0, locked: 1'b0, fail: 1'b0};
      STABLE:    outs_d = '{pll_resetb: 1'b1, pll_bypass: 1'b0, sys_rst_n: 1'b0, locked: 1'b0, fail: 1'b0};
      RUN:       outs_d = '{pll_resetb: 1'b1, pll_bypass: 1'b0, sys_rst_n: 1'b1, locked: 1'b1, fail: 1'b0};
      BYPASS:    outs_d = '{pll_resetb: 1'b0, pll_bypass: 1'b1, sys_rst_n: 1'b1, locked: 1'b0, fail: 1'b1};
      default:   outs_d = '0;
    endcase
  end

endmodule
